// File: rtl/mul_by_x4_plus_x2_serial.sv
// Serial GF(2) multiplier by (x^4 + x^2): q = p*x^4 ^ p*x^2, no reduction.
// Processes W bits per cycle, lowest chunk first, carrying 4 bits between chunks.
module mul_by_x4_plus_x2_serial #(
  parameter int N = 1120,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   p,
  output logic           busy,
  output logic           done,
  output logic [N+3:0]   q
);

  localparam int NC = N / W;
  localparam int CW = $clog2(NC + 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N+3:0]  q_q, q_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [3:0]    carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  chunk;
  logic [W+3:0]  ext;
  logic [W-1:0]  out_w;

  assign chunk = sh_q[W-1:0];

  // ext = {c,4'b0} ^ {2'b0,c,2'b0}, built bit by bit
  genvar gi;
  generate
    for (gi = 0; gi < W + 4; gi++) begin : g_ext
      logic t4, t2;
      if (gi >= 4) begin : g_t4
        assign t4 = chunk[gi-4];
      end else begin : g_t4z
        assign t4 = 1'b0;
      end
      if (gi >= 2 && gi < W + 2) begin : g_t2
        assign t2 = chunk[gi-2];
      end else begin : g_t2z
        assign t2 = 1'b0;
      end
      assign ext[gi] = t4 ^ t2;
    end
  endgenerate

  assign out_w = ext[W-1:0] ^ {{(W-4){1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    sh_d    = sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // a start coinciding with the done pulse is dropped
        if (start && !done_q) begin
          sh_d    = p;
          carry_d = 4'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        q_d[int'(cnt_q)*W +: W] = out_w;
        carry_d = ext[W+3:W];
        sh_d    = sh_q >> W;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CHUNK) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        q_d[N+3:N] = carry_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      sh_q    <= '0;
      carry_q <= 4'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      sh_q    <= sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;

endmodule

// File: tb/tb_mul_by_x4_plus_x2_serial.sv
// Randomized bench for mul_by_x4_plus_x2_serial against a shift/XOR product
// model and a long-division inverse for the round trip.
module tb_mul_by_x4_plus_x2_serial;
  localparam int N = 1120;
  localparam int W = 32;
  localparam int LAT = N / W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   p;
  logic           busy;
  logic           done;
  logic [N+3:0]   q;

  int n_checks = 0;
  int n_fail   = 0;

  mul_by_x4_plus_x2_serial #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .q     (q)
  );

  always #5 clk = ~clk;

  function automatic logic [N+3:0] mul_model(input logic [N-1:0] a);
    logic [N+3:0] e;
    e = {4'b0, a};
    return (e << 4) ^ (e << 2);
  endfunction

  // exact division by x^2*(x^2+1): drop x^2, then undo (1 + x^2) from the bottom up
  function automatic logic [N-1:0] div_model(input logic [N+3:0] m);
    logic [N+3:0] r;
    logic [N-1:0] a;
    r = m >> 2;
    a = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = r[i] ^ ((i >= 2) ? a[i-2] : 1'b0);
    end
    return a;
  endfunction

  function automatic logic [N-1:0] rand_p();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) begin
      v[i*32 +: 32] = $urandom;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [N+3:0] obs, input logic [N+3:0] exp);
    int first;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      first = -1;
      for (int i = N + 3; i >= 0; i--) begin
        if (obs[i] !== exp[i]) first = i;
      end
      $display("FAIL %s: got[127:0]=%h expected[127:0]=%h first differing bit %0d",
               tag, obs[127:0], exp[127:0], first);
    end
  endtask

  task automatic run_op(input string name, input logic [N-1:0] pv,
                        input int restart_at, input logic [N-1:0] p2);
    logic [N+3:0] expq;
    int cyc;
    expq = mul_model(pv);
    @(negedge clk);
    start = 1'b1;
    p     = pv;
    @(negedge clk);
    start = 1'b0;
    p     = rand_p();
    cyc   = 0;
    check({name, "_busy_run"}, {{(N+3){1'b0}}, busy}, 1);
    while (!done && cyc < 100) begin
      if (cyc == restart_at) begin
        start = 1'b1;
        p     = p2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({name, "_latency"}, cyc, LAT);
    check({name, "_q"}, q, expq);
    check({name, "_roundtrip"}, {4'b0, div_model(q)}, {4'b0, pv});
    check({name, "_busy_done"}, {{(N+3){1'b0}}, busy}, 0);
    // a start during the done cycle must be ignored
    start = 1'b1;
    p     = p2;
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_1cyc"}, {{(N+3){1'b0}}, done}, 0);
    check({name, "_start_in_done_ignored"}, {{(N+3){1'b0}}, busy}, 0);
    check({name, "_q_hold"}, q, expq);
    $display("op %s: latency %0d, q[127:0]=%h", name, cyc, q[127:0]);
  endtask

  initial begin
    logic [N-1:0] pv;
    logic [N+3:0] ev;
    int ndone;

    rst   = 1'b1;
    start = 1'b0;
    p     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {{(N+3){1'b0}}, busy}, 0);
    check("reset_done", {{(N+3){1'b0}}, done}, 0);
    check("reset_q", q, '0);
    rst = 1'b0;

    pv = '0;
    pv[1116:1113] = 4'hF;
    ev = '0;
    ev[1115] = 1'b1; ev[1116] = 1'b1; ev[1119] = 1'b1; ev[1120] = 1'b1;
    run_op("top_bits", pv, -1, rand_p());
    check("top_bits_exact", q, ev);

    pv = '0; pv[0] = 1'b1;
    run_op("one", pv, -1, rand_p());
    check("one_exact", q, {{(N-4){1'b0}}, 8'h14});

    pv = '0; pv[31] = 1'b1;
    ev = '0; ev[33] = 1'b1; ev[35] = 1'b1;
    run_op("chunk_boundary", pv, -1, rand_p());
    check("chunk_boundary_exact", q, ev);

    pv = '1;
    ev = '0; ev[2] = 1'b1; ev[3] = 1'b1; ev[N+2] = 1'b1; ev[N+3] = 1'b1;
    run_op("all_ones", pv, -1, rand_p());
    check("all_ones_exact", q, ev);

    run_op("restart_ignored", rand_p(), 4, rand_p());

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1;
    p     = rand_p();
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {{(N+3){1'b0}}, busy}, 0);
    check("midrst_done", {{(N+3){1'b0}}, done}, 0);
    check("midrst_q", q, '0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op("after_rst", rand_p(), -1, rand_p());

    for (int t = 0; t < 50; t++) begin
      run_op($sformatf("rand%0d", t), rand_p(), -1, rand_p());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
